// File: rtl/top_002_pkg.sv
// top_002_pkg: shared definitions for the COA teaching CPU.
// Provides the opcode encoding, ROM geometry, the default program image
// (as a lookup function) and the active-low seven-segment glyph table.
package top_002_pkg;

  localparam int ROM_DEPTH = 16;
  localparam int ROM_WIDTH = 8;
  localparam int PC_WIDTH  = 4;

  // Opcodes 9..E are unassigned and execute as NOP.
  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_IN  = 4'h2,
    OP_OUT = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_JMP = 4'h7,
    OP_JZ  = 4'h8,
    OP_HLT = 4'hF
  } opcode_e;

  // Default program: read switches, show them, then count up until the
  // accumulator wraps to zero and halt.
  function automatic logic [ROM_WIDTH-1:0] rom_word(input logic [PC_WIDTH-1:0] addr);
    logic [ROM_WIDTH-1:0] word;
    case (addr)
      4'd0:    word = 8'h20;  // IN
      4'd1:    word = 8'h30;  // OUT
      4'd2:    word = 8'h41;  // ADD 1
      4'd3:    word = 8'h30;  // OUT
      4'd4:    word = 8'h86;  // JZ 6
      4'd5:    word = 8'h72;  // JMP 2
      4'd6:    word = 8'hF0;  // HLT
      default: word = 8'h00;
    endcase
    return word;
  endfunction

  // Hex digit to active-low segments {dp,g,f,e,d,c,b,a}; dp stays dark.
  function automatic logic [7:0] seg_glyph(input logic [3:0] nibble);
    logic [7:0] seg;
    case (nibble)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      4'hF:    seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/top_002_seg7_scan.sv
// seg7_scan: multiplexed 4-digit seven-segment driver.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   nib0..nib3    hex nibbles for digits 0..3 (digit 0 is rightmost)
//   dis           active-low segments {dp,g,f,e,d,c,b,a}
//   cs            active-low digit selects, exactly one low
// The free-running counter is SCAN_BITS+2 wide; its top two bits pick the
// digit, so each digit is held for 2^SCAN_BITS clocks.
module seg7_scan
  import top_002_pkg::*;
#(
  parameter int SCAN_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] nib0,
  input  logic [3:0] nib1,
  input  logic [3:0] nib2,
  input  logic [3:0] nib3,
  output logic [7:0] dis,
  output logic [3:0] cs
);

  localparam int CW = SCAN_BITS + 2;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt_r;
  logic [1:0]    sel_s;
  logic [3:0]    nib_s;

  assign sel_s = cnt_r[CW-1 -: 2];

  // Scan counter: cleared by reset, otherwise free-running and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Digit mux and segment decode straight from the counter, no extra latency.
  always_comb begin
    cs    = 4'b1110;
    nib_s = nib0;
    case (sel_s)
      2'd0: begin cs = 4'b1110; nib_s = nib0; end
      2'd1: begin cs = 4'b1101; nib_s = nib1; end
      2'd2: begin cs = 4'b1011; nib_s = nib2; end
      2'd3: begin cs = 4'b0111; nib_s = nib3; end
      default: begin cs = 4'b1110; nib_s = nib0; end
    endcase
    dis = seg_glyph(nib_s);
  end

endmodule

// File: rtl/top_002.sv
// top_002: FPGA board top of the COA teaching CPU, an 8-bit single-cycle
// accumulator machine running from a 16-word constant ROM.
// Ports:
//   CLK    system clock, rising edge
//   RST    synchronous active-high reset
//   Data   8-bit switch bank, read only by IN
//   Dis    active-low segments {dp,g,f,e,d,c,b,a}
//   Cs     active-low digit selects (ACC lo, ACC hi, PC, opcode)
//   LED    output register written by OUT
module top_002
  import top_002_pkg::*;
#(
  parameter int SCAN_BITS = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] Data,
  output logic [7:0] Dis,
  output logic [3:0] Cs,
  output logic [7:0] LED
);

  logic [PC_WIDTH-1:0]  pc_r;
  logic [7:0]           acc_r;
  logic                 z_r;
  logic                 halt_r;
  logic [7:0]           led_r;

  logic [ROM_WIDTH-1:0] instr_s;
  logic [3:0]           op_s;
  logic [7:0]           imm_s;
  logic [PC_WIDTH-1:0]  pc_nxt_s;
  logic [7:0]           acc_nxt_s;
  logic                 z_nxt_s;
  logic                 halt_nxt_s;
  logic [7:0]           led_nxt_s;

  assign instr_s = rom_word(pc_r);
  assign op_s    = instr_s[7:4];
  assign imm_s   = {4'h0, instr_s[3:0]};

  // Next-state for one instruction; a halted machine simply holds everything.
  always_comb begin
    pc_nxt_s   = pc_r + 4'd1;
    acc_nxt_s  = acc_r;
    z_nxt_s    = z_r;
    halt_nxt_s = halt_r;
    led_nxt_s  = led_r;
    if (halt_r) begin
      pc_nxt_s = pc_r;
    end else begin
      case (op_s)
        OP_LDI: begin
          acc_nxt_s = imm_s;
          z_nxt_s   = (imm_s == 8'h00);
        end
        OP_IN: begin
          acc_nxt_s = Data;
          z_nxt_s   = (Data == 8'h00);
        end
        OP_OUT: begin
          led_nxt_s = acc_r;
        end
        OP_ADD: begin
          acc_nxt_s = acc_r + imm_s;
          z_nxt_s   = ((acc_r + imm_s) == 8'h00);
        end
        OP_SUB: begin
          acc_nxt_s = acc_r - imm_s;
          z_nxt_s   = ((acc_r - imm_s) == 8'h00);
        end
        OP_AND: begin
          acc_nxt_s = acc_r & imm_s;
          z_nxt_s   = ((acc_r & imm_s) == 8'h00);
        end
        OP_JMP: begin
          pc_nxt_s = instr_s[3:0];
        end
        OP_JZ: begin
          if (z_r) begin
            pc_nxt_s = instr_s[3:0];
          end else begin
            pc_nxt_s = pc_r + 4'd1;
          end
        end
        OP_HLT: begin
          // PC stays on the HLT so the display keeps pointing at it.
          pc_nxt_s   = pc_r;
          halt_nxt_s = 1'b1;
        end
        default: begin
          pc_nxt_s = pc_r + 4'd1;
        end
      endcase
    end
  end

  // Architectural state register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_r   <= 4'd0;
      acc_r  <= 8'h00;
      z_r    <= 1'b0;
      halt_r <= 1'b0;
      led_r  <= 8'h00;
    end else begin
      pc_r   <= pc_nxt_s;
      acc_r  <= acc_nxt_s;
      z_r    <= z_nxt_s;
      halt_r <= halt_nxt_s;
      led_r  <= led_nxt_s;
    end
  end

  assign LED = led_r;

  seg7_scan #(
    .SCAN_BITS(SCAN_BITS)
  ) u_scan (
    .clk  (CLK),
    .rst  (RST),
    .nib0 (acc_r[3:0]),
    .nib1 (acc_r[7:4]),
    .nib2 (pc_r),
    .nib3 (op_s),
    .dis  (Dis),
    .cs   (Cs)
  );

endmodule

// File: tb/tb_top_002.sv
// tb_top_002: directed self-checking bench for top_002 with SCAN_BITS=2.
module tb_top_002;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic [7:0] dis;
  logic [3:0] cs;
  logic [7:0] led;

  int tests_run    = 0;
  int tests_failed = 0;

  top_002 #(.SCAN_BITS(2)) dut (
    .CLK  (clk),
    .RST  (rst),
    .Data (data),
    .Dis  (dis),
    .Cs   (cs),
    .LED  (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the wanted digit is selected (bounded), then record it.
  task automatic wait_cs(input string tag, input logic [3:0] want);
    for (int i = 0; i < 40; i++) begin
      if (cs == want) break;
      tick();
    end
    check(tag, {4'h0, cs}, {4'h0, want});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Start-up sequence with Data=0x0A: edges 0, 1, 3 and 7 after release.
  task automatic startup_0a(input string pfx);
    data = 8'h0A;
    tick();                                    // edge 0: ACC=0A, scan cnt 1
    check({pfx, "_e0_cs"},  {4'h0, cs}, 8'h0E);
    check({pfx, "_e0_dis"}, dis, 8'h88);
    tick();                                    // edge 1: LED=0A
    check({pfx, "_e1_led"}, led, 8'h0A);
    tick();
    tick();                                    // edge 3: LED=0B, scan cnt 4
    check({pfx, "_e3_led"}, led, 8'h0B);
    check({pfx, "_e3_cs"},  {4'h0, cs}, 8'h0D);
    check({pfx, "_e3_dis"}, dis, 8'hC0);
    repeat (4) tick();                         // edge 7: LED=0C
    check({pfx, "_e7_led"}, led, 8'h0C);
  endtask

  logic [7:0] cs_tab [4];
  int         led_bad;

  initial begin
    cs_tab[0] = 8'h0E;
    cs_tab[1] = 8'h0D;
    cs_tab[2] = 8'h0B;
    cs_tab[3] = 8'h07;
    rst  = 1'b1;
    data = 8'h00;
    #1;

    // Reset state.
    tick();
    tick();
    check("rst_led", led, 8'h00);
    check("rst_cs",  {4'h0, cs}, 8'h0E);
    check("rst_dis", dis, 8'hC0);
    rst = 1'b0;

    // Start-up, then wrap and halt.
    startup_0a("su");
    repeat (1100) tick();
    check("halt_led", led, 8'h00);
    wait_cs("halt_pc_cs", 4'b1011);
    check("halt_pc_dis", dis, 8'h82);
    wait_cs("halt_op_cs", 4'b0111);
    check("halt_op_dis", dis, 8'h8E);
    wait_cs("halt_acc_cs", 4'b1110);
    check("halt_acc_dis", dis, 8'hC0);
    led_bad = 0;
    data = 8'h55;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (led != 8'h00) led_bad++;
    end
    check("halt_hold_led_bad", led_bad[7:0], 8'h00);
    wait_cs("halt2_pc_cs", 4'b1011);
    check("halt2_pc_dis", dis, 8'h82);

    // Data sampled only by IN.
    data = 8'hFE;
    do_reset();
    tick();                                    // edge 0: ACC=FE
    data = 8'h33;
    tick();
    check("ds_e1_led", led, 8'hFE);
    tick();
    tick();
    check("ds_e3_led", led, 8'hFF);
    repeat (4) tick();
    check("ds_e7_led", led, 8'h00);
    repeat (20) tick();
    check("ds_end_led", led, 8'h00);
    wait_cs("ds_pc_cs", 4'b1011);
    check("ds_pc_dis", dis, 8'h82);

    // Display scan: each digit held 4 clocks, wraps after 16.
    data = 8'h0A;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("scan_cs_%0d", i), {4'h0, cs}, cs_tab[((i + 1) / 4) % 4]);
    end

    // Reset mid-run restarts the program exactly.
    data = 8'h0A;
    do_reset();
    repeat (50) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_led", led, 8'h00);
    check("mid_rst_cs",  {4'h0, cs}, 8'h0E);
    check("mid_rst_dis", dis, 8'hC0);
    rst = 1'b0;
    startup_0a("mid");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
